layer_serializer: RTL

//   Parallel-to-serial bridge between two linear layers. Captures a layer's parallel

---
 rtl/linear_pkg.sv | 15 +
 rtl/relu_act.sv | 17 +
 rtl/layer_serializer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/linear_pkg.sv
// Shared definitions for the linear-layer datapath blocks.
//   DATA_WIDTH : default word width for the layer datapath
//   word_t     : signed fixed-point word at the default width
//   idx_w(n)   : bit width of an index counting 0..n-1 (minimum 1)
package linear_pkg;

  localparam int unsigned DATA_WIDTH = 24;

  typedef logic signed [DATA_WIDTH-1:0] word_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_act.sv
// Combinational ReLU on a two's-complement word. With ENABLE=0 the word passes
// through unchanged; otherwise negative words become zero.
//   a_i : input word
//   y_o : activated word (same width, no saturation)
module relu_act #(
  parameter int unsigned WIDTH  = 24,
  parameter bit          ENABLE = 1'b1
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = (ENABLE && a_i[WIDTH-1]) ? '0 : a_i;
  end

endmodule

// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between two linear layers. A full vector captured on
// an i_valid pulse is replayed one word per cycle, with a two-bank ping-pong
// buffer so one vector can be captured while the other streams.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_valid     : din holds a complete vector this cycle
//   din         : parallel vector, NUM_NODES words
//   i_ready     : a free bank exists, a capture this cycle will succeed
//   dout        : serial word (ReLU applied when APPLY_RELU != 0)
//   o_valid     : dout valid this cycle
//   o_last      : dout is element NUM_NODES-1 of its vector
//   o_overflow  : sticky, a vector was dropped since reset
module layer_serializer #(
  parameter int unsigned DATA_WIDTH = linear_pkg::DATA_WIDTH,
  parameter int unsigned NUM_NODES  = 500,
  parameter int unsigned APPLY_RELU = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_overflow
);
  import linear_pkg::idx_w;

  localparam int unsigned   IW       = idx_w(NUM_NODES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NODES - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, rd_idx;
  logic                  rd_q, rd_d, rd_sel;
  logic [1:0]            full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, last_q;
  logic [DATA_WIDTH-1:0] bank_q [2][NUM_NODES];
  logic                  capture, wr_bank, emit, last_beat;
  logic [DATA_WIDTH-1:0] raw_word, act_word;

  assign i_ready = ~&full_q;
  assign capture = i_valid & i_ready;
  // Bank 0 when free; otherwise bank 1, which must be free whenever i_ready is high.
  assign wr_bank = full_q[0];
  assign ovf_d   = ovf_q | (i_valid & ~i_ready);

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned k = 0; k < NUM_NODES; k++) begin
        bank_q[wr_bank][k] <= din[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      valid_q <= emit;
      last_q  <= last_beat;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    full_d  = full_q;
    if (capture) full_d[wr_bank] = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (emit) begin
          rd_d    = rd_sel;
          idx_d   = IW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_beat) begin
          // Free the active bank on its last beat; a capture landing in the other
          // bank at this same edge continues the stream without a gap.
          full_d[rd_q] = 1'b0;
          rd_d         = ~rd_q;
          idx_d        = '0;
          state_d      = full_d[~rd_q] ? STREAM : IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: which word is registered onto dout at this edge
  always_comb begin
    emit      = 1'b0;
    last_beat = 1'b0;
    rd_sel    = rd_q;
    rd_idx    = idx_q;
    unique case (state_q)
      IDLE: begin
        // At most one bank can be full while idle, so serving it keeps capture order.
        if (|full_q) begin
          emit   = 1'b1;
          rd_sel = ~full_q[0];
          rd_idx = '0;
        end
      end
      STREAM: begin
        emit      = 1'b1;
        last_beat = (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  assign raw_word = bank_q[rd_sel][rd_idx];

  relu_act #(
    .WIDTH  (DATA_WIDTH),
    .ENABLE (APPLY_RELU != 0)
  ) u_relu (
    .a_i (raw_word),
    .y_o (act_word)
  );

  assign dout_d     = emit ? act_word : '0;
  assign dout       = dout_q;
  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_overflow = ovf_q;

endmodule
